// File: rtl/bf_machine.sv
// bf_machine: Brainfuck execution engine with on-chip tape,
// hardware loop stack and valid/ready byte input/output.
module bf_machine #(
    parameter int CELL_W      = 8,
    parameter int DATA_AW     = 6,
    parameter int PROG_AW     = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_en,
    input  logic               start,
    output logic [PROG_AW-1:0] prog_addr,
    input  logic [2:0]         prog_code,
    input  logic               prog_end,
    output logic [CELL_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic [CELL_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CELL_W-1:0]  cell_val,
    output logic [DATA_AW-1:0] data_ptr,
    output logic               busy,
    output logic               halted,
    output logic               error,
    output logic [1:0]         err_code
);
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam int SI_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
    localparam logic [PROG_AW:0] DEPTH_ONE = {{PROG_AW{1'b0}}, 1'b1};

    localparam int OP_RIGHT = 0;
    localparam int OP_LEFT  = 1;
    localparam int OP_INC   = 2;
    localparam int OP_DEC   = 3;
    localparam int OP_OUT   = 4;
    localparam int OP_IN    = 5;
    localparam int OP_LOOP  = 6;
    localparam int OP_END   = 7;

    typedef enum logic [2:0] {
        S_CLEAR, S_EXEC, S_OUT, S_IN, S_SKIP, S_HALT, S_ERR
    } state_t;

    state_t state, state_nx;

    logic [CELL_W-1:0]  tape  [2**DATA_AW];
    logic [PROG_AW-1:0] stack [STACK_DEPTH];

    logic [PROG_AW-1:0] pc_nx, pc_inc, top;
    logic [DATA_AW-1:0] dp_nx, clr_idx, clr_idx_nx;
    logic [SP_W-1:0]    sp, sp_nx, sp_m1;
    logic [PROG_AW:0]   depth, depth_nx;
    logic [1:0]         ecode, ecode_nx;
    logic [CELL_W-1:0]  odata_nx;
    logic               tape_we, push;
    logic [DATA_AW-1:0] tape_wa;
    logic [CELL_W-1:0]  tape_wd;
    logic [7:0]         op;

    assign op       = 8'b1 << prog_code;
    assign pc_inc   = prog_addr + 1'b1;
    assign sp_m1    = sp - 1'b1;
    assign top      = stack[sp_m1[SI_W-1:0]];
    assign cell_val = tape[data_ptr];

    assign busy      = (state == S_CLEAR);
    assign halted    = (state == S_HALT);
    assign error     = (state == S_ERR);
    assign out_valid = (state == S_OUT);
    assign in_ready  = (state == S_IN);
    assign err_code  = error ? ecode : 2'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_CLEAR;
            prog_addr <= '0;
            data_ptr  <= '0;
            sp        <= '0;
            depth     <= '0;
            clr_idx   <= '0;
            ecode     <= 2'd0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            prog_addr <= pc_nx;
            data_ptr  <= dp_nx;
            sp        <= sp_nx;
            depth     <= depth_nx;
            clr_idx   <= clr_idx_nx;
            ecode     <= ecode_nx;
            out_data  <= odata_nx;
        end
    end

    // Tape and stack are plain memories; CLEAR zeroes the tape.
    always_ff @(posedge clk) begin
        if (tape_we) tape[tape_wa] <= tape_wd;
        if (push) stack[sp[SI_W-1:0]] <= prog_addr;
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = prog_addr;
        dp_nx      = data_ptr;
        sp_nx      = sp;
        depth_nx   = depth;
        clr_idx_nx = '0;
        ecode_nx   = ecode;
        odata_nx   = out_data;
        tape_we    = 1'b0;
        tape_wa    = data_ptr;
        tape_wd    = cell_val;
        push       = 1'b0;
        unique case (state)
            S_CLEAR: begin
                tape_we    = 1'b1;
                tape_wa    = clr_idx;
                tape_wd    = '0;
                clr_idx_nx = clr_idx + 1'b1;
                if (&clr_idx) begin
                    state_nx = S_EXEC;
                    pc_nx    = '0;
                    dp_nx    = '0;
                    sp_nx    = '0;
                end
            end
            S_EXEC: begin
                if (step_en && prog_end) begin
                    state_nx = S_HALT;
                end else if (step_en) begin
                    unique case (1'b1)
                        op[OP_RIGHT]: begin
                            dp_nx = data_ptr + 1'b1;
                            pc_nx = pc_inc;
                        end
                        op[OP_LEFT]: begin
                            dp_nx = data_ptr - 1'b1;
                            pc_nx = pc_inc;
                        end
                        op[OP_INC]: begin
                            tape_we = 1'b1;
                            tape_wd = cell_val + 1'b1;
                            pc_nx   = pc_inc;
                        end
                        op[OP_DEC]: begin
                            tape_we = 1'b1;
                            tape_wd = cell_val - 1'b1;
                            pc_nx   = pc_inc;
                        end
                        op[OP_OUT]: begin
                            odata_nx = cell_val;
                            state_nx = S_OUT;
                        end
                        op[OP_IN]: state_nx = S_IN;
                        op[OP_LOOP]: begin
                            if (cell_val == '0) begin
                                depth_nx = DEPTH_ONE;
                                pc_nx    = pc_inc;
                                state_nx = S_SKIP;
                            end else if (sp == SP_FULL) begin
                                ecode_nx = 2'd1;
                                state_nx = S_ERR;
                            end else begin
                                push  = 1'b1;
                                sp_nx = sp + 1'b1;
                                pc_nx = pc_inc;
                            end
                        end
                        op[OP_END]: begin
                            if (sp == '0) begin
                                ecode_nx = 2'd2;
                                state_nx = S_ERR;
                            end else if (cell_val != '0) begin
                                pc_nx = top + 1'b1;
                            end else begin
                                sp_nx = sp_m1;
                                pc_nx = pc_inc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    pc_nx    = pc_inc;
                    state_nx = S_EXEC;
                end
            end
            S_IN: begin
                if (in_valid) begin
                    tape_we  = 1'b1;
                    tape_wd  = in_data;
                    pc_nx    = pc_inc;
                    state_nx = S_EXEC;
                end
            end
            S_SKIP: begin
                if (prog_end) begin
                    ecode_nx = 2'd3;
                    state_nx = S_ERR;
                end else begin
                    pc_nx = pc_inc;
                    if (op[OP_LOOP]) depth_nx = depth + 1'b1;
                    if (op[OP_END]) begin
                        depth_nx = depth - 1'b1;
                        if (depth == DEPTH_ONE) state_nx = S_EXEC;
                    end
                end
            end
            S_HALT, S_ERR: begin
                if (start) begin
                    state_nx = S_CLEAR;
                    ecode_nx = 2'd0;
                    pc_nx    = '0;
                    dp_nx    = '0;
                end
            end
            default: state_nx = S_CLEAR;
        endcase
    end
endmodule
